write_sram: RTL

- Write-side counterpart of the packet-buffer SRAM reader.
- Accepts a packet as a sop/eop/vld word stream and stores it in SRAM in 16-word blocks, with block addresses drawn from a free-block allocator.
- For each packet it emits the descriptor information the read side consumes: per-block base address pulses, last-block valid and last-block word index.
- Sits between an ingress port and the shared packet SRAM; the first word of each packet is its header.

---
 rtl/write_sram.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/write_sram.sv
// write_sram: write side of the packet-buffer SRAM.
//
// Accepts a packet as a sop/eop/vld word stream and writes it into SRAM in
// 16-word blocks. Block indices come from a free-block allocator through a
// one-entry prefetch buffer, so the next block is normally already on hand
// when the current one fills. For every packet it emits the descriptor
// information the read side consumes: a base-address pulse per opened block,
// the captured header word, and the last-block word index at eop.
//
// Optional feature (compile-time macro WRITE_SRAM_ERR_CNT_EN):
//   adds o_err_cnt, a 16-bit saturating count of dropped non-sop words in
//   idle plus sop words seen mid-packet. Without the macro the port and the
//   counter do not exist.
//
// Ports:
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_wr_sop/eop/vld/data input word stream (sop/eop qualified by vld)
//   o_wr_rdy              a word is accepted this cycle when vld && rdy
//   o_free_blk_req        request to the free-block allocator
//   i_free_blk_vld/addr   allocator grant and granted block index
//   o_sram_wr_en/addr/data SRAM write port (one cycle after the accepted beat)
//   o_blk_addr(_vld)      base word address of each block as it is opened
//   o_last_blk_vld/_n     eop pulse and eop word index within the last block
//   o_pkt_hdr(_vld)       captured sop word
//   o_pkt_done            pulse once the eop word has been written
//   o_err_cnt             protocol error count (WRITE_SRAM_ERR_CNT_EN only)

module write_sram #(
   parameter int unsigned AWIDTH     = 14,
   parameter int unsigned BLK_AWIDTH = 10,
   parameter int unsigned DWIDTH     = 32
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_wr_sop,
   input  logic                         i_wr_eop,
   input  logic                         i_wr_vld,
   input  logic [DWIDTH-1:0]            i_wr_data,
   output logic                         o_wr_rdy,
   output logic                         o_free_blk_req,
   input  logic                         i_free_blk_vld,
   input  logic [BLK_AWIDTH-1:0]        i_free_blk_addr,
   output logic                         o_sram_wr_en,
   output logic [AWIDTH-1:0]            o_sram_wr_addr,
   output logic [DWIDTH-1:0]            o_sram_wr_data,
   output logic [AWIDTH-1:0]            o_blk_addr,
   output logic                         o_blk_addr_vld,
   output logic                         o_last_blk_vld,
   output logic [AWIDTH-BLK_AWIDTH-1:0] o_last_blk_n,
   output logic [DWIDTH-1:0]            o_pkt_hdr,
   output logic                         o_pkt_hdr_vld,
   output logic                         o_pkt_done
`ifdef WRITE_SRAM_ERR_CNT_EN
   ,
   output logic [15:0]                  o_err_cnt
`endif
);

   localparam int unsigned OWIDTH = AWIDTH - BLK_AWIDTH;
   localparam logic [OWIDTH-1:0] OffLast = {OWIDTH{1'b1}};

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StWaitBlk
   } state_e;

   state_e                  state_q, state_d;
   logic                    buf_vld_q, buf_vld_d;
   logic [BLK_AWIDTH-1:0]   buf_blk_q, buf_blk_d;
   logic [BLK_AWIDTH-1:0]   cur_blk_q, cur_blk_d;
   // Offset of the next word to be written within cur_blk.
   logic [OWIDTH-1:0]       offset_q, offset_d;

   logic                    wr_rdy;
   logic                    beat;
   logic                    grant;
   logic                    consume;
   logic                    grant_direct;

   // Decoded write for the beat accepted this cycle.
   logic                    wr_go;
   logic                    wr_first;
   logic                    wr_last;
   logic [BLK_AWIDTH-1:0]   wr_blk;
   logic [OWIDTH-1:0]       wr_off;

   // ---------------------------------------------------------------------
   // Handshakes
   // ---------------------------------------------------------------------
   // Ready depends only on registered state, keeping it free of input paths.
   always_comb begin
      wr_rdy = 1'b0;
      case (state_q)
         StIdle:    wr_rdy = buf_vld_q;
         // The last slot of a block is only taken once the next block is in
         // hand, so a packet never stalls with a half-written word.
         StWrite:   wr_rdy = (offset_q != OffLast) || buf_vld_q;
         StWaitBlk: wr_rdy = 1'b0;
         default:   wr_rdy = 1'b0;
      endcase
   end

   assign o_wr_rdy       = wr_rdy;
   assign o_free_blk_req = !buf_vld_q && !i_rst;
   assign beat           = i_wr_vld && wr_rdy;
   assign grant          = i_free_blk_vld && o_free_blk_req;

   // ---------------------------------------------------------------------
   // Next-state and write decode
   // ---------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cur_blk_d    = cur_blk_q;
      offset_d     = offset_q;
      consume      = 1'b0;
      grant_direct = 1'b0;
      wr_go        = 1'b0;
      wr_first     = 1'b0;
      wr_last      = 1'b0;
      wr_blk       = cur_blk_q;
      wr_off       = offset_q;

      case (state_q)
         StIdle: begin
            // Non-sop words arriving between packets are dropped.
            if (beat && i_wr_sop) begin
               wr_go     = 1'b1;
               wr_first  = 1'b1;
               wr_blk    = buf_blk_q;
               wr_off    = '0;
               cur_blk_d = buf_blk_q;
               consume   = 1'b1;
               if (i_wr_eop) begin
                  wr_last  = 1'b1;
                  offset_d = '0;
               end else begin
                  offset_d = OWIDTH'(1);
                  state_d  = StWrite;
               end
            end
         end

         StWrite: begin
            // A sop here is written as ordinary data.
            if (beat) begin
               wr_go   = 1'b1;
               wr_last = i_wr_eop;
               if (i_wr_eop) begin
                  offset_d = '0;
                  state_d  = StIdle;
               end else if (offset_q == OffLast) begin
                  offset_d = '0;
                  if (buf_vld_q) begin
                     cur_blk_d = buf_blk_q;
                     consume   = 1'b1;
                  end else begin
                     state_d = StWaitBlk;
                  end
               end else begin
                  offset_d = offset_q + OWIDTH'(1);
               end
            end
         end

         StWaitBlk: begin
            // The grant goes straight to cur_blk rather than through the buffer.
            if (grant) begin
               grant_direct = 1'b1;
               cur_blk_d    = i_free_blk_addr;
               offset_d     = '0;
               state_d      = StWrite;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   // Prefetch buffer: a grant can only land while it is empty, so load and
   // consume never collide; load still wins should both ever be seen.
   always_comb begin
      buf_vld_d = buf_vld_q;
      buf_blk_d = buf_blk_q;
      if (grant && !grant_direct) begin
         buf_vld_d = 1'b1;
         buf_blk_d = i_free_blk_addr;
      end else if (consume) begin
         buf_vld_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= StIdle;
         buf_vld_q <= 1'b0;
         buf_blk_q <= '0;
         cur_blk_q <= '0;
         offset_q  <= '0;
      end else begin
         state_q   <= state_d;
         buf_vld_q <= buf_vld_d;
         buf_blk_q <= buf_blk_d;
         cur_blk_q <= cur_blk_d;
         offset_q  <= offset_d;
      end
   end

   // ---------------------------------------------------------------------
   // Registered write port and descriptor outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_sram_wr_en   <= 1'b0;
         o_sram_wr_addr <= '0;
         o_sram_wr_data <= '0;
         o_blk_addr     <= '0;
         o_blk_addr_vld <= 1'b0;
         o_last_blk_vld <= 1'b0;
         o_last_blk_n   <= '0;
         o_pkt_hdr      <= '0;
         o_pkt_hdr_vld  <= 1'b0;
         o_pkt_done     <= 1'b0;
      end else begin
         o_sram_wr_en   <= wr_go;
         o_blk_addr_vld <= wr_go && (wr_off == '0);
         o_pkt_hdr_vld  <= wr_go && wr_first;
         o_last_blk_vld <= wr_go && wr_last;
         o_pkt_done     <= wr_go && wr_last;
         if (wr_go) begin
            o_sram_wr_addr <= {wr_blk, wr_off};
            o_sram_wr_data <= i_wr_data;
            if (wr_off == '0) begin
               o_blk_addr <= {wr_blk, {OWIDTH{1'b0}}};
            end
            if (wr_first) begin
               o_pkt_hdr <= i_wr_data;
            end
            if (wr_last) begin
               o_last_blk_n <= wr_off;
            end
         end
      end
   end

`ifdef WRITE_SRAM_ERR_CNT_EN
   // ---------------------------------------------------------------------
   // Protocol error counter
   // ---------------------------------------------------------------------
   logic [15:0] err_cnt_q;
   logic        err_inc;

   assign err_inc = beat && (((state_q == StIdle) && !i_wr_sop) ||
                             ((state_q == StWrite) && i_wr_sop));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_cnt_q <= '0;
      end else if (err_inc && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign o_err_cnt = err_cnt_q;
`endif

endmodule
